// File: rtl/mem_lsu.sv
// mem_lsu: load/store unit between the EX and WB stages.
//   Accepts one request in IDLE, performs at most one data-memory access with
//   a bounded wait, then presents a result to WB until it is taken.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   i_valid / o_ready        EX-side request handshake
//   i_result, i_data_store,  request payload (address or ALU result, store
//   i_pc, i_opcode, i_func3  data, PC, opcode, funct3)
//   o_valid / i_wb_ready     WB-side handshake
//   o_wb_data, o_opcode,     WB payload
//   o_misaligned, o_bus_err
//   o_stb, o_wr_en, o_addr,  data-memory request (word address, lane enables)
//   o_wr_data, o_byte_en
//   i_ack, i_read_data       data-memory response
module mem_lsu #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [31:0]       i_result,
   input  logic [31:0]       i_data_store,
   input  logic [31:0]       i_pc,
   input  logic [6:0]        i_opcode,
   input  logic [2:0]        i_func3,
   output logic              o_valid,
   input  logic              i_wb_ready,
   output logic [31:0]       o_wb_data,
   output logic [6:0]        o_opcode,
   output logic              o_misaligned,
   output logic              o_bus_err,
   output logic              o_stb,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic [31:0]       o_wr_data,
   output logic [3:0]        o_byte_en,
   input  logic              i_ack,
   input  logic [31:0]       i_read_data
);

   localparam logic [6:0] OP_LD = 7'b0000011;
   localparam logic [6:0] OP_S  = 7'b0100011;
   localparam logic [6:0] OP_J  = 7'b1101111;
   localparam logic [6:0] OP_JR = 7'b1100111;

   localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {
      IDLE,
      BUS,
      RESP
   } state_e;

   state_e            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [31:0]       addr_q, addr_d;
   logic [2:0]        func3_q, func3_d;
   logic [6:0]        opcode_q, opcode_d;
   logic              wr_en_q, wr_en_d;
   logic [31:0]       wr_data_q, wr_data_d;
   logic [3:0]        byte_en_q, byte_en_d;
   logic [31:0]       wb_data_q, wb_data_d;
   logic              misaligned_q, misaligned_d;
   logic              bus_err_q, bus_err_d;

   logic              in_is_mem;
   logic              in_is_store;
   logic              in_aligned;
   logic [31:0]       st_data;
   logic [3:0]        st_be;
   logic [31:0]       ld_shift;
   logic [31:0]       ld_data;
   logic              timeout_hit;

   // Alignment check and store lane steering from the incoming request.
   always_comb begin
      in_is_store = (i_opcode == OP_S);
      in_is_mem   = (i_opcode == OP_LD) || in_is_store;
      in_aligned  = 1'b1;
      st_data     = i_data_store;
      st_be       = 4'b1111;
      case (i_func3[1:0])
         2'b00: begin
            in_aligned = 1'b1;
            st_data    = {4{i_data_store[7:0]}};
            st_be      = 4'b0001 << i_result[1:0];
         end
         2'b01: begin
            in_aligned = ~i_result[0];
            st_data    = {2{i_data_store[15:0]}};
            st_be      = 4'b0011 << i_result[1:0];
         end
         default: begin
            in_aligned = (i_result[1:0] == 2'b00);
            st_data    = i_data_store;
            st_be      = 4'b1111;
         end
      endcase
   end

   // Load lane extraction: move the addressed lane down to bit 0, then extend.
   always_comb begin
      ld_shift = i_read_data >> {addr_q[1:0], 3'b000};
      case (func3_q)
         3'b000:  ld_data = {{24{ld_shift[7]}}, ld_shift[7:0]};
         3'b001:  ld_data = {{16{ld_shift[15]}}, ld_shift[15:0]};
         3'b100:  ld_data = {24'h0, ld_shift[7:0]};
         3'b101:  ld_data = {16'h0, ld_shift[15:0]};
         default: ld_data = ld_shift;
      endcase
   end

   // The counter holds the number of completed no-ack BUS cycles, so the
   // TIMEOUT-th silent cycle is the one where it still reads TIMEOUT-1.
   always_comb begin
      timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT - 1));
   end

   // State register and payload flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         addr_q       <= '0;
         func3_q      <= '0;
         opcode_q     <= '0;
         wr_en_q      <= 1'b0;
         wr_data_q    <= '0;
         byte_en_q    <= '0;
         wb_data_q    <= '0;
         misaligned_q <= 1'b0;
         bus_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         addr_q       <= addr_d;
         func3_q      <= func3_d;
         opcode_q     <= opcode_d;
         wr_en_q      <= wr_en_d;
         wr_data_q    <= wr_data_d;
         byte_en_q    <= byte_en_d;
         wb_data_q    <= wb_data_d;
         misaligned_q <= misaligned_d;
         bus_err_q    <= bus_err_d;
      end
   end

   // Next-state and payload update.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      addr_d       = addr_q;
      func3_d      = func3_q;
      opcode_d     = opcode_q;
      wr_en_d      = wr_en_q;
      wr_data_d    = wr_data_q;
      byte_en_d    = byte_en_q;
      wb_data_d    = wb_data_q;
      misaligned_d = misaligned_q;
      bus_err_d    = bus_err_q;
      case (state_q)
         IDLE: begin
            if (i_valid) begin
               opcode_d     = i_opcode;
               func3_d      = i_func3;
               addr_d       = i_result;
               misaligned_d = 1'b0;
               bus_err_d    = 1'b0;
               wr_en_d      = in_is_store;
               wr_data_d    = in_is_store ? st_data : '0;
               byte_en_d    = st_be;
               cnt_d        = '0;
               if (in_is_mem && in_aligned) begin
                  state_d = BUS;
               end else begin
                  state_d = RESP;
                  if (in_is_mem) begin
                     misaligned_d = 1'b1;
                     wb_data_d    = i_result;
                  end else if ((i_opcode == OP_J) || (i_opcode == OP_JR)) begin
                     wb_data_d = i_pc + 32'd4;
                  end else begin
                     wb_data_d = i_result;
                  end
               end
            end
         end
         BUS: begin
            // An ack in the timeout cycle still counts as a normal completion.
            if (i_ack) begin
               state_d   = RESP;
               wb_data_d = wr_en_q ? '0 : ld_data;
            end else if (timeout_hit) begin
               state_d   = RESP;
               bus_err_d = 1'b1;
               wb_data_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         RESP: begin
            if (i_wb_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: memory request is only visible while in BUS.
   always_comb begin
      o_ready      = (state_q == IDLE) && !rst;
      o_valid      = (state_q == RESP);
      o_wb_data    = wb_data_q;
      o_opcode     = opcode_q;
      o_misaligned = misaligned_q;
      o_bus_err    = bus_err_q;
      o_stb        = 1'b0;
      o_wr_en      = 1'b0;
      o_addr       = '0;
      o_wr_data    = '0;
      o_byte_en    = '0;
      if (state_q == BUS) begin
         o_stb     = 1'b1;
         o_wr_en   = wr_en_q;
         o_addr    = {addr_q[ADDR_W-1:2], 2'b00};
         o_wr_data = wr_data_q;
         o_byte_en = byte_en_q;
      end
   end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random operations
// compared against a byte-level reference model of the load/store rules.
module tb_mem_lsu;

   localparam int TO = 4;
   localparam logic [6:0] OP_LD  = 7'b0000011;
   localparam logic [6:0] OP_S   = 7'b0100011;
   localparam logic [6:0] OP_J   = 7'b1101111;
   localparam logic [6:0] OP_JR  = 7'b1100111;
   localparam logic [6:0] OP_ALU = 7'b0110011;
   localparam logic [6:0] OP_LUI = 7'b0110111;

   logic        clk = 1'b0;
   logic        rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_result;
   logic [31:0] i_data_store;
   logic [31:0] i_pc;
   logic [6:0]  i_opcode;
   logic [2:0]  i_func3;
   logic        o_valid;
   logic        i_wb_ready;
   logic [31:0] o_wb_data;
   logic [6:0]  o_opcode;
   logic        o_misaligned;
   logic        o_bus_err;
   logic        o_stb;
   logic        o_wr_en;
   logic [31:0] o_addr;
   logic [31:0] o_wr_data;
   logic [3:0]  o_byte_en;
   logic        i_ack;
   logic [31:0] i_read_data;

   int checks = 0;
   int errors = 0;

   mem_lsu #(.ADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .i_valid(i_valid), .o_ready(o_ready),
      .i_result(i_result), .i_data_store(i_data_store), .i_pc(i_pc),
      .i_opcode(i_opcode), .i_func3(i_func3),
      .o_valid(o_valid), .i_wb_ready(i_wb_ready),
      .o_wb_data(o_wb_data), .o_opcode(o_opcode),
      .o_misaligned(o_misaligned), .o_bus_err(o_bus_err),
      .o_stb(o_stb), .o_wr_en(o_wr_en), .o_addr(o_addr),
      .o_wr_data(o_wr_data), .o_byte_en(o_byte_en),
      .i_ack(i_ack), .i_read_data(i_read_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit          is_bus;
      bit          is_store;
      int          stb_cycles;
      logic [31:0] addr;
      logic [31:0] wr_data;
      logic [3:0]  be;
      logic [31:0] wb;
      bit          mis;
      bit          err;
   } exp_t;

   task automatic chk(input string tag, input string what,
                      input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s.%s observed=0x%0h expected=0x%0h", tag, what, obs, exp);
      end
   endtask

   // Reference: ack_at is the BUS cycle (1-based) in which ack is driven, 0 = never.
   function automatic exp_t model(input logic [6:0] op, input logic [2:0] f3,
                                  input logic [31:0] res, input logic [31:0] dst,
                                  input logic [31:0] pc, input logic [31:0] rdata,
                                  input int ack_at);
      exp_t e;
      int size;
      int off;
      logic [31:0] v;
      e.is_bus = 0; e.is_store = (op == OP_S); e.stb_cycles = 0;
      e.addr = '0; e.wr_data = '0; e.be = '0; e.wb = '0; e.mis = 0; e.err = 0;
      if (op == OP_LD || op == OP_S) begin
         size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
         off  = int'(res % 32'd4);
         if ((res % 32'(size)) != 0) begin
            e.mis = 1;
            e.wb  = res;
         end else begin
            e.is_bus = 1;
            e.addr   = res - 32'(off);
            for (int i = 0; i < 4; i++) begin
               if (i >= off && i < off + size) e.be[i] = 1'b1;
               e.wr_data[8*i +: 8] = dst[8*(i % size) +: 8];
            end
            if (ack_at > 0 && ack_at <= TO) begin
               e.stb_cycles = ack_at;
               if (e.is_store) begin
                  e.wb = '0;
               end else begin
                  v = rdata >> (8 * off);
                  if (size == 1) begin
                     v = v % 32'd256;
                     if (!f3[2] && v >= 32'd128) v = v - 32'd256;
                  end else if (size == 2) begin
                     v = v % 32'd65536;
                     if (!f3[2] && v >= 32'd32768) v = v - 32'd65536;
                  end
                  e.wb = v;
               end
            end else begin
               e.stb_cycles = TO;
               e.err        = 1;
               e.wb         = '0;
            end
         end
      end else if (op == OP_J || op == OP_JR) begin
         e.wb = pc + 32'd4;
      end else begin
         e.wb = res;
      end
      return e;
   endfunction

   task automatic run_op(input string tag, input logic [6:0] op, input logic [2:0] f3,
                         input logic [31:0] res, input logic [31:0] dst,
                         input logic [31:0] pc, input logic [31:0] rdata,
                         input int ack_at, input int wb_wait);
      exp_t e;
      e = model(op, f3, res, dst, pc, rdata, ack_at);
      @(negedge clk);
      chk(tag, "ready", 32'(o_ready), 32'd1);
      i_valid = 1'b1; i_opcode = op; i_func3 = f3; i_result = res;
      i_data_store = dst; i_pc = pc;
      i_ack = 1'(($urandom % 2));
      i_wb_ready = 1'($urandom % 2);
      for (int k = 1; k <= e.stb_cycles; k++) begin
         @(negedge clk);
         chk(tag, "stb", 32'(o_stb), 32'd1);
         chk(tag, "valid_bus", 32'(o_valid), 32'd0);
         chk(tag, "addr", o_addr, e.addr);
         chk(tag, "wr_en", 32'(o_wr_en), 32'(e.is_store));
         if (e.is_store) begin
            chk(tag, "wr_data", o_wr_data, e.wr_data);
            chk(tag, "byte_en", 32'(o_byte_en), 32'(e.be));
         end
         // Payload changes and spurious valids here must be ignored.
         i_valid = 1'($urandom % 2); i_result = $urandom; i_opcode = 7'($urandom);
         i_func3 = 3'($urandom); i_pc = $urandom; i_data_store = $urandom;
         i_wb_ready = 1'($urandom % 2);
         i_ack = (k == ack_at);
         i_read_data = (k == ack_at) ? rdata : $urandom;
      end
      for (int w = 0; w <= wb_wait; w++) begin
         @(negedge clk);
         chk(tag, "valid", 32'(o_valid), 32'd1);
         chk(tag, "ready_resp", 32'(o_ready), 32'd0);
         chk(tag, "stb_resp", 32'(o_stb), 32'd0);
         chk(tag, "wb_data", o_wb_data, e.wb);
         chk(tag, "opcode", 32'(o_opcode), 32'(op));
         chk(tag, "misaligned", 32'(o_misaligned), 32'(e.mis));
         chk(tag, "bus_err", 32'(o_bus_err), 32'(e.err));
         i_valid = 1'($urandom % 2);
         i_ack = 1'($urandom % 2);
         i_read_data = $urandom;
         i_wb_ready = (w == wb_wait);
      end
      @(negedge clk);
      chk(tag, "valid_done", 32'(o_valid), 32'd0);
      chk(tag, "ready_done", 32'(o_ready), 32'd1);
      i_valid = 1'b0; i_ack = 1'b0; i_wb_ready = 1'b0;
   endtask

   initial begin
      logic [6:0]  op;
      logic [2:0]  f3;
      logic [31:0] res;
      int          sel;
      logic [2:0]  ld_f3 [5];
      ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

      rst = 1'b1; i_valid = 1'b0; i_result = '0; i_data_store = '0; i_pc = '0;
      i_opcode = '0; i_func3 = '0; i_wb_ready = 1'b0; i_ack = 1'b0; i_read_data = '0;
      repeat (3) @(negedge clk);
      chk("reset", "ready", 32'(o_ready), 32'd0);
      chk("reset", "valid", 32'(o_valid), 32'd0);
      chk("reset", "stb", 32'(o_stb), 32'd0);
      chk("reset", "wb_data", o_wb_data, 32'd0);
      chk("reset", "opcode", 32'(o_opcode), 32'd0);
      rst = 1'b0;

      run_op("lb_sext", OP_LD, 3'd0, 32'h103, $urandom, $urandom, 32'h80AA_BBCC, 3, 0);
      run_op("sh_lane", OP_S, 3'd1, 32'h202, 32'h1234_ABCD, $urandom, $urandom, 1, 0);
      run_op("lw_misal", OP_LD, 3'd2, 32'h101, $urandom, $urandom, $urandom, 1, 0);
      run_op("lw_tmo", OP_LD, 3'd2, 32'h40, $urandom, $urandom, $urandom, 0, 0);
      run_op("lw_ack4", OP_LD, 3'd2, 32'h44, $urandom, $urandom, 32'hDEAD_BEEF, 4, 1);
      run_op("lw_late", OP_LD, 3'd2, 32'h48, $urandom, $urandom, $urandom, 5, 0);
      run_op("jal_wrap", OP_J, 3'd0, $urandom, $urandom, 32'hFFFF_FFFC, $urandom, 0, 3);

      // Reset in the middle of a bus access; the ack after reset must be dropped.
      @(negedge clk);
      i_valid = 1'b1; i_opcode = OP_LD; i_func3 = 3'd2; i_result = 32'h300;
      @(negedge clk);
      i_valid = 1'b0;
      chk("rst_bus", "stb_pre", 32'(o_stb), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_bus", "stb", 32'(o_stb), 32'd0);
      chk("rst_bus", "ready", 32'(o_ready), 32'd0);
      chk("rst_bus", "valid", 32'(o_valid), 32'd0);
      chk("rst_bus", "wb_data", o_wb_data, 32'd0);
      chk("rst_bus", "opcode", 32'(o_opcode), 32'd0);
      chk("rst_bus", "misaligned", 32'(o_misaligned), 32'd0);
      chk("rst_bus", "bus_err", 32'(o_bus_err), 32'd0);
      chk("rst_bus", "addr", o_addr, 32'd0);
      chk("rst_bus", "wr_en", 32'(o_wr_en), 32'd0);
      chk("rst_bus", "byte_en", 32'(o_byte_en), 32'd0);
      chk("rst_bus", "wr_data", o_wr_data, 32'd0);
      rst = 1'b0; i_ack = 1'b1; i_read_data = $urandom;
      @(negedge clk);
      chk("rst_bus", "ready_after", 32'(o_ready), 32'd1);
      chk("rst_bus", "valid_after", 32'(o_valid), 32'd0);
      chk("rst_bus", "stb_after", 32'(o_stb), 32'd0);
      i_ack = 1'b0;
      @(negedge clk);
      chk("rst_bus", "valid_late", 32'(o_valid), 32'd0);

      for (int n = 0; n < 80; n++) begin
         sel = int'($urandom % 6);
         case (sel)
            0, 1: begin op = OP_LD; f3 = ld_f3[$urandom % 5]; end
            2:    begin op = OP_S;  f3 = 3'($urandom % 3); end
            3:    begin op = OP_J;  f3 = 3'($urandom); end
            4:    begin op = OP_JR; f3 = 3'($urandom); end
            default: begin op = ($urandom % 2 == 0) ? OP_ALU : OP_LUI; f3 = 3'($urandom); end
         endcase
         res = $urandom;
         if ($urandom % 2 == 0) res[1:0] = 2'b00;
         run_op("rand", op, f3, res, $urandom, $urandom, $urandom,
                $urandom_range(0, 6), $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_lsu.md
MEM_LSU -- requirements
Module: mem_lsu

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, data-memory address width; data path fixed at 32 bits.
REQ-002 SHALL have parameter TIMEOUT, default 16, maximum bus-wait cycles; 0 disables the timeout.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have ports i_valid input 1, o_ready output 1: EX-side request handshake.
REQ-006 SHALL have ports i_result input 32 (ALU result / address), i_data_store input 32, i_pc input 32, i_opcode input 7, i_func3 input 3: request payload.
REQ-007 SHALL have ports o_valid output 1, i_wb_ready input 1: WB-side handshake.
REQ-008 SHALL have ports o_wb_data output 32, o_opcode output 7, o_misaligned output 1, o_bus_err output 1: WB payload.
REQ-009 SHALL have ports o_stb output 1, o_wr_en output 1, o_addr output ADDR_W, o_wr_data output 32, o_byte_en output 4: data-memory request.
REQ-010 SHALL have ports i_ack input 1, i_read_data input 32: data-memory response.

Function
REQ-011 SHALL implement FSM states IDLE, BUS, RESP.
REQ-012 SHALL drive o_ready = 1 only in IDLE with rst low; request accepted when i_valid & o_ready; payload registered on accept.
REQ-013 On accept of a non-memory opcode (not `LD`, not `S`), SHALL go to RESP next cycle with o_wb_data = i_pc+4 (mod 2^32) for `J`/`JR`, else i_result.
REQ-014 On accept of aligned `LD`/`S`, SHALL go to BUS; aligned = byte ops any address, LH/LHU/SH addr[0]=0, LW/SW addr[1:0]=0.
REQ-015 On accept of misaligned `LD`/`S`, SHALL skip BUS, go to RESP with o_misaligned=1, o_wb_data = address, no o_stb pulse.
REQ-016 In BUS, SHALL hold o_stb=1, o_wr_en=1 for `S` else 0, o_addr = {addr[ADDR_W-1:2],2'b00}, o_wr_data, o_byte_en stable until exit.
REQ-017 Outside BUS, SHALL drive o_stb=0, o_wr_en=0, o_addr=0, o_byte_en=0, o_wr_data=0.
REQ-018 Store lanes SHALL be: SB data={4{d[7:0]}}, byte_en=4'b0001<<off; SH data={2{d[15:0]}}, byte_en=4'b0011<<off; SW data=d, byte_en=4'b1111 (off=addr[1:0]).
REQ-019 Loads SHALL shift i_read_data right by 8*off, then LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-020 i_ack SHALL be sampled only in BUS; on i_ack SHALL capture load data (stores: o_wb_data=0) and go to RESP next cycle.
REQ-021 Wait counter SHALL clear on BUS entry and increment each BUS cycle without ack; at count == TIMEOUT (TIMEOUT>0) SHALL go to RESP with o_bus_err=1, o_wb_data=0.
REQ-022 i_ack in the same cycle the counter reaches TIMEOUT SHALL win: normal completion, o_bus_err=0.
REQ-023 In RESP, SHALL hold o_valid=1 and all WB payload stable until i_wb_ready=1, then return to IDLE next cycle.
REQ-024 o_opcode SHALL equal the registered opcode whenever o_valid=1.
REQ-025 i_ack outside BUS and i_valid outside IDLE SHALL be ignored with no state change.
REQ-026 Throughput SHALL be at most one operation per 2 cycles; memory op latency = accept + bus wait + 1 cycle to o_valid.

Reset
REQ-027 With rst high at a clock edge, SHALL enter IDLE and clear counter, o_valid, o_wb_data, o_opcode, o_misaligned, o_bus_err, all memory outputs to 0.
REQ-028 While rst is high, o_ready SHALL be 0.
REQ-029 Reset in BUS SHALL drop o_stb the next cycle; an i_ack arriving after reset SHALL be ignored.

Verification
REQ-030 LB at addr 0x103, i_read_data=0x80AA_BBCC, ack after 2 cycles -> o_stb 3 cycles, o_addr 0x100, o_wb_data 0xFFFF_FF80, o_valid 4 cycles after accept.
REQ-031 SH addr 0x202, data 0x1234_ABCD -> o_wr_en=1, o_addr 0x200, o_wr_data 0xABCD_ABCD, o_byte_en 4'b1100.
REQ-032 LW addr 0x101 -> no o_stb, o_misaligned=1, o_wb_data 0x101.
REQ-033 TIMEOUT=4, LW with no ack -> o_stb exactly 4 BUS cycles then o_bus_err=1, o_wb_data=0; repeat with ack on 4th cycle -> o_bus_err=0.
REQ-034 JAL with i_pc 0xFFFF_FFFC, i_wb_ready low 3 cycles -> o_wb_data 0x0000_0000, o_valid and payload held 3 cycles, IDLE one cycle after i_wb_ready.
REQ-035 rst pulsed during BUS, then ack -> o_stb low next cycle, late ack ignored, all outputs 0, o_ready=1 after rst falls.
